// File: rtl/demux_dispatcher.sv
// Buffered dispatcher: queues {dest, data} transactions in a FIFO and presents the
// head on its destination lane only, with per-lane valid/ready and a stall counter.
module demux_dispatcher #(
    parameter int N = 1,
    parameter int S = 2,
    parameter int D = 2,
    parameter int W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N-1:0]                in_data,
    input  logic [S-1:0]                in_dest,
    output logic [(2**S)-1:0][N-1:0]    result,
    output logic [(2**S)-1:0]           out_valid,
    input  logic [(2**S)-1:0]           out_ready,
    output logic [D:0]                  count,
    output logic [W-1:0]                stall_cnt
);

    localparam int LANES = 2**S;
    localparam int DEPTH = 2**D;

    typedef enum logic {IDLE, SEND} state_t;

    typedef struct packed {
        logic [S-1:0] dest;
        logic [N-1:0] data;
    } entry_t;

    entry_t                      mem [DEPTH];
    logic   [D-1:0]              wr_ptr_q, wr_ptr_d;
    logic   [D-1:0]              rd_ptr_q, rd_ptr_d;
    logic   [D:0]                count_q, count_d;
    state_t                      state_q, state_d;
    logic   [LANES-1:0]          out_valid_q, out_valid_d;
    logic   [LANES-1:0][N-1:0]   result_q, result_d;
    logic   [W-1:0]              stall_q, stall_d;

    logic   push, pop, hs;
    entry_t head;

    assign in_ready  = (count_q != DEPTH[D:0]);
    assign count     = count_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign stall_cnt = stall_q;
    assign head      = mem[rd_ptr_q];

    always_comb begin
        push = in_valid && in_ready;
        // Only the selected lane's ready matters, since out_valid_q is one-hot.
        hs   = (state_q == SEND) && (|(out_valid_q & out_ready));
        pop  = (count_q != '0) && ((state_q == IDLE) || hs);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        stall_d     = stall_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (pop) begin
            state_d               = SEND;
            out_valid_d           = '0;
            out_valid_d[head.dest] = 1'b1;
            result_d              = '0;
            result_d[head.dest]   = head.data;
            stall_d               = '0;
        end else if (hs) begin
            state_d     = IDLE;
            out_valid_d = '0;
            result_d    = '0;
            stall_d     = '0;
        end else if (state_q == SEND) begin
            stall_d = (stall_q == '1) ? stall_q : stall_q + 1'b1;
        end else begin
            stall_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= '{dest: in_dest, data: in_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            out_valid_q <= '0;
            result_q    <= '0;
            stall_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            stall_q     <= stall_d;
        end
    end

endmodule

// File: tb/tb_demux_dispatcher.sv
// Directed bench for demux_dispatcher (N=8, S=2, D=2) with a W=4 twin for saturation.
module tb_demux_dispatcher;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = '0;
    logic [1:0]       in_dest = '0;
    logic [3:0]       out_ready = '0;
    logic             in_ready, in_ready_s;
    logic [3:0][7:0]  result, result_s;
    logic [3:0]       out_valid, out_valid_s;
    logic [2:0]       count, count_s;
    logic [7:0]       stall_cnt;
    logic [3:0]       stall_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    demux_dispatcher #(.N(8), .S(2), .D(2), .W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest), .result(result),
        .out_valid(out_valid), .out_ready(out_ready), .count(count),
        .stall_cnt(stall_cnt)
    );

    demux_dispatcher #(.N(8), .S(2), .D(2), .W(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_dest(in_dest), .result(result_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .count(count_s),
        .stall_cnt(stall_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ov"},    64'(out_valid), 64'h0);
        check({tag, "_res"},   64'(result),    64'h0);
        check({tag, "_cnt"},   64'(count),     64'h0);
        check({tag, "_rdy"},   64'(in_ready),  64'h1);
        check({tag, "_stall"}, 64'(stall_cnt), 64'h0);
    endtask

    task automatic single_transfer(input string tag);
        in_valid = 1'b1; in_data = 8'hA5; in_dest = 2'd2; out_ready = 4'b1111;
        tick();
        in_valid = 1'b0;
        check({tag, "_cnt1"}, 64'(count), 64'h1);
        check({tag, "_ov1"},  64'(out_valid), 64'h0);
        tick();
        check({tag, "_ov2"},  64'(out_valid), 64'h4);
        check({tag, "_res2"}, 64'(result), 64'h00A5_0000);
        check({tag, "_cnt2"}, 64'(count), 64'h0);
        tick();
        check({tag, "_ov3"},  64'(out_valid), 64'h0);
        check({tag, "_res3"}, 64'(result), 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst = 1'b1;
        #1 check_reset_state("por");
        #9 rst = 1'b0;

        // Single transfer
        single_transfer("single");

        // Back-to-back across all lanes, no bubbles
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'h10 + 8'(i); in_dest = 2'(i);
            tick();
            if (i >= 1) begin
                check($sformatf("b2b_ov%0d", i), 64'(out_valid), 64'(4'b0001 << (i - 1)));
                check($sformatf("b2b_res%0d", i), 64'(result), 64'(32'(8'h10 + 8'(i - 1)) << (8 * (i - 1))));
            end
        end
        in_valid = 1'b0;
        tick();
        check("b2b_ov4",  64'(out_valid), 64'h8);
        check("b2b_res4", 64'(result), 64'h1300_0000);
        tick();
        check("b2b_idle", 64'(out_valid), 64'h0);

        // Full: four in FIFO plus one in the output stage
        out_ready = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'h20 + 8'(i); in_dest = 2'(i % 4);
            check($sformatf("full_rdy%0d", i), 64'(in_ready), 64'h1);
            tick();
        end
        in_data = 8'h25; in_dest = 2'd1;
        check("full_cnt",  64'(count), 64'h4);
        check("full_rdy",  64'(in_ready), 64'h0);
        check("full_ov",   64'(out_valid), 64'h1);
        check("full_res",  64'(result), 64'h0000_0020);
        tick();
        check("full_hold", 64'(count), 64'h4);
        out_ready = 4'b0001;
        tick();
        out_ready = 4'b0000;
        check("full_pop_cnt", 64'(count), 64'h3);
        check("full_pop_ov",  64'(out_valid), 64'h2);
        check("full_pop_res", 64'(result), 64'h0000_2100);
        check("full_pop_rdy", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        check("full_6th_cnt", 64'(count), 64'h4);
        check("full_stall1",  64'(stall_cnt), 64'h1);
        out_ready = 4'b1111;
        tick(); check("drain_ov0", 64'(out_valid), 64'h4); check("drain_res0", 64'(result), 64'h0022_0000);
        tick(); check("drain_ov1", 64'(out_valid), 64'h8); check("drain_res1", 64'(result), 64'h2300_0000);
        tick(); check("drain_ov2", 64'(out_valid), 64'h1); check("drain_res2", 64'(result), 64'h0000_0024);
        tick(); check("drain_ov3", 64'(out_valid), 64'h2); check("drain_res3", 64'(result), 64'h0000_2500);
        check("drain_cnt", 64'(count), 64'h0);
        tick(); check("drain_idle", 64'(out_valid), 64'h0);

        // Wrong-lane ready does not complete the handshake
        out_ready = 4'b1101;
        in_valid = 1'b1; in_data = 8'h31; in_dest = 2'd1;
        tick();
        in_valid = 1'b0;
        tick();
        check("wl_ov0",    64'(out_valid), 64'h2);
        check("wl_stall0", 64'(stall_cnt), 64'h0);
        for (int i = 0; i < 5; i++) tick();
        check("wl_ov5",    64'(out_valid), 64'h2);
        check("wl_stall5", 64'(stall_cnt), 64'h5);
        out_ready = 4'b1111;
        tick();
        check("wl_hs_stall", 64'(stall_cnt), 64'h0);
        check("wl_hs_ov",    64'(out_valid), 64'h0);

        // Saturation of the stall counter (W=4 twin)
        out_ready = 4'b0000;
        in_valid = 1'b1; in_data = 8'h44; in_dest = 2'd3;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("sat_s15",  64'(stall_cnt_s), 64'hF);
        for (int i = 0; i < 5; i++) tick();
        check("sat_s20",  64'(stall_cnt_s), 64'hF);
        check("sat_w8",   64'(stall_cnt), 64'd20);
        check("sat_ov",   64'(out_valid), 64'h8);

        // Async reset in the middle of a cycle while SEND with count=3
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'h50 + 8'(i); in_dest = 2'(i);
            tick();
        end
        in_valid = 1'b0;
        check("ar_pre_cnt", 64'(count), 64'h3);
        check("ar_pre_ov",  64'(out_valid), 64'h8);
        #1 rst = 1'b1;
        #1 check_reset_state("ar");
        check("ar_sat_stall", 64'(stall_cnt_s), 64'h0);
        #2 rst = 1'b0;
        single_transfer("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
